// File: rtl/ahb_defs.sv
// Shared AHB-Lite encodings and byte-lane helper, used by the slave memory and the master port.
package ahb_defs;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Little-endian write strobe; illegal sizes give no lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised RAM with per-byte write strobes and a combinational read port.
module ahb_mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave fronting an on-chip RAM: programmable wait states, two-cycle ERROR
// for misaligned, illegal-size or out-of-range transfers.
module ahb_slave_mem
    import ahb_defs::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    slv_state_e            state, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            lanes_q;
    logic                  write_q;
    logic [3:0]            wcnt, wcnt_d;
    logic                  accept, take, addr_err, oor;
    logic [3:0]            we;
    logic [31:0]           rdata;
    logic [ADDR_WIDTH-1:0] widx;
    logic                  unused_bits;

    assign widx        = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HBURST, HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    // A fully populated array cannot be addressed out of range.
    generate
        if (MEM_WORDS < (1 << ADDR_WIDTH)) begin : g_oor
            assign oor = (32'(widx) >= 32'(MEM_WORDS));
        end else begin : g_full
            assign oor = 1'b0;
        end
    endgenerate

    assign addr_err = (HSIZE > HSIZE_WORD)
                    || ((HSIZE == HSIZE_HALF) && HADDR[0])
                    || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
                    || oor;

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        state_d   = state;
        wcnt_d    = wcnt;
        take      = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (wcnt == 4'd0) state_d = ST_DATA;
                else              wcnt_d  = wcnt - 4'd1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
        // Address phases can only complete in states that drive HREADYOUT high.
        if (state == ST_IDLE || state == ST_DATA || state == ST_ERR2) begin
            state_d = ST_IDLE;
            if (accept) begin
                take = 1'b1;
                if (addr_err) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    wcnt_d  = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = ST_DATA;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            wcnt    <= 4'd0;
            addr_q  <= '0;
            lanes_q <= 4'd0;
            write_q <= 1'b0;
        end else begin
            state <= state_d;
            wcnt  <= wcnt_d;
            if (take) begin
                addr_q  <= widx;
                lanes_q <= lane_mask(HSIZE, HADDR[1:0]);
                write_q <= HWRITE;
            end
        end
    end

    // Gating with HRESETn keeps a reset on the final data edge from committing.
    assign we     = (state == ST_DATA && write_q && HRESETn) ? lanes_q : 4'b0000;
    assign HRDATA = (state == ST_DATA && !write_q) ? rdata : 32'h0;

    ahb_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (HCLK),
        .we   (we),
        .addr (addr_q),
        .wdata(HWDATA),
        .rdata(rdata)
    );

endmodule
